// File: rtl/clk_div_pkg.sv
package clk_div_pkg;

  localparam int unsigned CNT_W_DEFAULT = 8;

  typedef logic [CNT_W_DEFAULT-1:0] half_cnt_t;

  typedef enum logic {
    ARM_IDLE  = 1'b0,
    ARM_ARMED = 1'b1
  } arm_state_e;

  function automatic int unsigned expected_period(input int unsigned div);
    return 2 * div;
  endfunction

endpackage

// File: rtl/div_edge_sampler.sv
module div_edge_sampler (
  input  logic clk,
  input  logic rst,
  input  logic div_i,
  output logic h0_o,
  output logic h1_o,
  output logic rise0_o,
  output logic rise1_o
);

  logic n_q;
  logic n_hold_q;
  logic p_q;
  logic h0_q;
  logic h1_q;
  logic prev_q;

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      n_q <= 1'b0;
    end else begin
      n_q <= div_i;
    end
  end

  // n_hold_q re-times the negedge sample so the pair register sees n_k and p_k together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_hold_q <= 1'b0;
      p_q      <= 1'b0;
      h0_q     <= 1'b0;
      h1_q     <= 1'b0;
      prev_q   <= 1'b0;
    end else begin
      n_hold_q <= n_q;
      p_q      <= div_i;
      h0_q     <= n_hold_q;
      h1_q     <= p_q;
      prev_q   <= h1_q;
    end
  end

  assign h0_o    = h0_q;
  assign h1_o    = h1_q;
  assign rise0_o = !prev_q && h0_q;
  assign rise1_o = !h0_q && h1_q;

endmodule

// File: rtl/clk_div_monitor.sv
module clk_div_monitor
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W    = CNT_W_DEFAULT,
  parameter int unsigned EXP_DIV  = 5,
  parameter int unsigned DUTY_TOL = 0,
  parameter int unsigned LOCK_CNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             div_i,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_o,
  output logic             meas_valid_o,
  output logic             locked_o,
  output logic             ratio_err_o,
  output logic             duty_err_o,
  output logic             overflow_o
);

  localparam int unsigned MW      = CNT_W + 1;
  localparam int unsigned MATCH_W = $clog2(LOCK_CNT + 1);

  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
  localparam logic [MW-1:0]      CNT_MAX_W = {1'b0, CNT_MAX};
  localparam logic [MW-1:0]      EXP_P     = MW'(expected_period(EXP_DIV));
  localparam logic [MW-1:0]      TOL       = MW'(DUTY_TOL);
  localparam logic [MATCH_W-1:0] MATCH_MAX = MATCH_W'(LOCK_CNT);

  logic h0;
  logic h1;
  logic rise0;
  logic rise1;

  div_edge_sampler u_sampler (
    .clk     (clk),
    .rst     (rst),
    .div_i   (div_i),
    .h0_o    (h0),
    .h1_o    (h1),
    .rise0_o (rise0),
    .rise1_o (rise1)
  );

  arm_state_e arm_q, arm_d;

  logic [CNT_W-1:0]   hc_q, hc_d;
  logic [CNT_W-1:0]   hi_q, hi_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic [CNT_W-1:0]   high_q, high_d;
  logic               valid_q, valid_d;
  logic               locked_q, locked_d;
  logic               ratio_q, ratio_d;
  logic               duty_q, duty_d;
  logic               ovf_q, ovf_d;
  logic [MATCH_W-1:0] match_q, match_d;

  logic          rise;
  logic          sat;
  logic [MW-1:0] hc_sum;
  logic [MW-1:0] hi_sum;
  logic [MW-1:0] meas_p;
  logic [MW-1:0] meas_h;
  logic [MW-1:0] two_h;
  logic [MW-1:0] duty_diff;

  // Measurement arithmetic runs at CNT_W+1 bits so 2*high never wraps.
  always_comb begin
    rise      = rise0 || rise1;
    sat       = (hc_q == CNT_MAX);
    hc_sum    = {1'b0, hc_q} + MW'(2);
    hi_sum    = {1'b0, hi_q} + MW'(h0) + MW'(h1);
    meas_p    = rise0 ? {1'b0, hc_q} : ({1'b0, hc_q} + MW'(1));
    meas_h    = rise0 ? {1'b0, hi_q} : ({1'b0, hi_q} + MW'(h0));
    two_h     = meas_h << 1;
    duty_diff = (two_h >= meas_p) ? (two_h - meas_p) : (meas_p - two_h);
  end

  always_comb begin
    arm_d    = arm_q;
    hc_d     = hc_q;
    hi_d     = hi_q;
    period_d = period_q;
    high_d   = high_q;
    valid_d  = 1'b0;
    ratio_d  = ratio_q;
    duty_d   = duty_q;
    ovf_d    = ovf_q;
    match_d  = match_q;

    if (!en) begin
      arm_d   = ARM_IDLE;
      hc_d    = '0;
      hi_d    = '0;
      ovf_d   = 1'b0;
      match_d = '0;
    end else if (rise) begin
      if (rise0) begin
        hc_d = CNT_W'(2);
        hi_d = CNT_W'(1) + CNT_W'(h1);
      end else begin
        hc_d = CNT_W'(1);
        hi_d = CNT_W'(1);
      end

      if (arm_q == ARM_IDLE) begin
        arm_d = ARM_ARMED;
      end else if (!sat) begin
        valid_d  = 1'b1;
        period_d = meas_p[CNT_W-1:0];
        high_d   = meas_h[CNT_W-1:0];
        ratio_d  = (meas_p != EXP_P);
        duty_d   = (duty_diff > TOL);
        if (meas_p[CNT_W-1:0] == period_q) begin
          match_d = (match_q == MATCH_MAX) ? match_q : (match_q + MATCH_W'(1));
        end else begin
          match_d = '0;
        end
      end
    end else begin
      hc_d = (hc_sum >= CNT_MAX_W) ? CNT_MAX : hc_sum[CNT_W-1:0];
      hi_d = (hi_sum >= CNT_MAX_W) ? CNT_MAX : hi_sum[CNT_W-1:0];
      if (hc_sum >= CNT_MAX_W) begin
        ovf_d   = 1'b1;
        match_d = '0;
      end
    end

    locked_d = (match_d == MATCH_MAX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arm_q    <= ARM_IDLE;
      hc_q     <= '0;
      hi_q     <= '0;
      period_q <= '0;
      high_q   <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      ratio_q  <= 1'b0;
      duty_q   <= 1'b0;
      ovf_q    <= 1'b0;
      match_q  <= '0;
    end else begin
      arm_q    <= arm_d;
      hc_q     <= hc_d;
      hi_q     <= hi_d;
      period_q <= period_d;
      high_q   <= high_d;
      valid_q  <= valid_d;
      locked_q <= locked_d;
      ratio_q  <= ratio_d;
      duty_q   <= duty_d;
      ovf_q    <= ovf_d;
      match_q  <= match_d;
    end
  end

  assign period_o     = period_q;
  assign high_o       = high_q;
  assign meas_valid_o = valid_q;
  assign locked_o     = locked_q;
  assign ratio_err_o  = ratio_q;
  assign duty_err_o   = duty_q;
  assign overflow_o   = ovf_q;

endmodule

// File: doc/clk_div_monitor.md
Name: clk_div_monitor

Overview:
- Receive-side checker for the odd-ratio clock divider output.
- Samples the divided clock on both edges of the source clock, so resolution is one half-cycle of clk.
- Measures period and high time of each divided-clock cycle in half-cycles; flags ratio and duty-cycle errors; declares lock after repeated stable measurements.
- Sits beside the divider in the clock subsystem; also used as a self-checking monitor in benches.

Parameters:
- CNT_W, 8: width of the half-cycle counters and of period_o/high_o.
- EXP_DIV, 5: expected division ratio; expected period is 2*EXP_DIV half-cycles.
- DUTY_TOL, 0: allowed |2*high - period| in half-cycles.
- LOCK_CNT, 4: consecutive equal periods required for lock.

Ports:
- clk  in  1  source clock; div_i is derived from it synchronously.
- rst  in  1  asynchronous reset, active-high.
- en  in  1  measurement enable; low clears all measurement state synchronously.
- div_i  in  1  divided clock under test.
- period_o  out  CNT_W  last measured period, in half-cycles.
- high_o  out  CNT_W  last measured high time, in half-cycles.
- meas_valid_o  out  1  one-cycle pulse when period_o/high_o update.
- locked_o  out  1  period stable for LOCK_CNT consecutive compares.
- ratio_err_o  out  1  last measurement period != 2*EXP_DIV.
- duty_err_o  out  1  last measurement |2*high - period| > DUTY_TOL.
- overflow_o  out  1  sticky; half-cycle counter saturated.

Behaviour:
- Reset values: all outputs 0; internal counters and sample flops 0; armed=0.
- Sampling:
  - p_k = div_i captured at posedge k.
  - n_k = div_i captured at the negedge between posedge k-1 and k.
  - These are the only negedge flops.
- Processing: at each posedge, the registered pair (h0=n_k, h1=p_k) is processed, using prev=p_{k-1}.
  - rise0 = !prev & h0.
  - rise1 = !h0 & h1.
  - rise0 and rise1 are mutually exclusive by construction.
- Counters:
  - hc counts half-samples since the last rise, including the rise sample.
  - hi counts the high half-samples in the same span.
- Per processed pair:
  - No rise: hc += 2; hi += h0 + h1.
  - rise0: measured (period, high) = (hc, hi); then hc = 2, hi = 1 + h1.
  - rise1: measured (period, high) = (hc + 1, hi + h0); then hc = 1, hi = 1.
- Arming: the first rise after reset or after en goes high only sets armed=1. It produces no measurement.
- Output timing: when armed and a rise occurs, in the next cycle:
  - meas_valid_o pulses.
  - period_o and high_o load the measured values.
  - ratio_err_o and duty_err_o update.
- Latency: meas_valid_o pulses 2 clk posedges after the posedge that follows the sampled rise.
- Between measurements, period_o, high_o and both error flags hold their values.
- Lock:
  - match counter += 1 when a new period equals the previous period; saturates at LOCK_CNT.
  - On a mismatch, the match counter returns to 0 and locked_o drops in the same cycle as meas_valid_o.
  - locked_o = (match == LOCK_CNT).
- Overflow:
  - hc saturates at 2^CNT_W - 1, then overflow_o sets and locked_o clears.
  - A measurement taken while saturated is suppressed: no meas_valid_o pulse.
  - The counters restart on the next rise.
  - overflow_o clears only on rst or en low.
- en low: synchronously clears all counters, armed, match counter, locked_o and overflow_o. period_o, high_o and the error flags hold.
- rst mid-measurement: asynchronous clear to reset values; the next rise re-arms.
- div_i constant: no measurements are produced; overflow_o asserts after saturation.
- Arithmetic: compares are done at CNT_W+1 bits, so 2*high cannot overflow.

Decomposition:
- Package clk_div_pkg:
  - CNT_W default.
  - Expected-period function 2*EXP_DIV.
  - Half-cycle count typedef.
- One sub-module, div_edge_sampler:
  - Contains the negedge and posedge capture flops, the pair register, and rise0/rise1 generation.
  - This keeps all negedge logic isolated.
- Top level: counters, lock logic, error logic.

Test Plan:
- 50% divide-by-5 (clk period 10 ns; 25 ns high, 25 ns low), en=1: period_o=10, high_o=5, no errors; locked_o=1 at the 5th meas_valid_o pulse.
- Posedge-only divide-by-5 (30 ns high, 20 ns low): high_o=6, duty_err_o=1, ratio_err_o=0, locked_o still asserts.
- Divide-by-4 (20/20 ns): period_o=8, high_o=4, ratio_err_o=1, duty_err_o=0.
- Switch from div5 to div4 after lock: the first div4 measurement gives period_o=8 and locked_o=0 in that cycle; locked_o reasserts after 4 more stable periods.
- div_i held at 0 after one rise: overflow_o=1 after 255 half-cycles (about 128 clk), no meas_valid_o; en low for one cycle clears overflow_o.
- rst pulsed mid-period, then div5 resumes: all outputs 0 immediately; the first rise only arms; the next rise gives period_o=10.
